fir_stream_ctrl: RTL
====================

# fir_stream_ctrl

Sequencer and flow-control wrapper for the 4-tap pipelined FIR datapath. It accepts input samples over a valid/ready stream and drives the FIR's `ena` and `data_in`. It tracks which pipeline slots hold real samples and captures finished results into an output FIFO with valid/ready backpressure. A flush sequence emits the convolution tail and drains the pipeline so the filter is left zeroed.

## Interface
Parameters:
- DATA_WIDTH, 18: input sample width.
- OUT_WIDTH, 38: FIR result width.
- N_TAPS, 4: filter taps. Sets the tail length N_TAPS-1.
- LATENCY, 4: FIR pipeline depth in `ena` advances.
- FIFO_DEPTH, 4: output FIFO entries. Must be a power of two, ≥2.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  input sample valid.
- s_data  in  DATA_WIDTH  input sample, signed.
- s_ready  out  1  controller accepts `s_data` this cycle.
- fir_ena  out  1  advance enable to the FIR.
- fir_data_in  out  DATA_WIDTH  sample to the FIR (`s_data`, or 0 during flush).
- fir_data_out  in  OUT_WIDTH  FIR output register.
- m_valid  out  1  result available at the FIFO head.
- m_data  out  OUT_WIDTH  result, signed.
- m_ready  in  1  downstream consumes the head.
- flush  in  1  single-cycle flush request.
- flush_busy  out  1  high while in FLUSH_TAIL or FLUSH_DRAIN.
- flush_done  out  1  one-cycle pulse when the flush completes.

## Operation
- `vld_sr[LATENCY-1:0]` shifts only when `fir_ena` is high. `vld_sr[0]` is loaded with the slot-is-real flag.
- `tail_pend` is high when `vld_sr[LATENCY-1]` is 1 and the current result is not yet captured. It is cleared when pushed, and re-evaluated after each `ena`.
- Push into the FIFO happens when `tail_pend` is high and the FIFO is not full. The pushed value is `fir_data_out`.
- `adv_ok` = !tail_pend | !fifo_full. This guarantees `ena` never overwrites an uncaptured result.
- State machine has three states: RUN, FLUSH_TAIL, FLUSH_DRAIN.
- RUN:
  - s_ready = adv_ok.
  - fir_ena = s_valid & s_ready.
  - fir_data_in = s_data.
  - The real flag is 1.
  - `flush` goes to FLUSH_TAIL with cnt = N_TAPS-1. A flush in the same cycle as an accepted sample takes effect after that sample.
- FLUSH_TAIL:
  - s_ready = 0.
  - fir_ena = adv_ok.
  - fir_data_in = 0, real flag 1.
  - cnt decrements on each `ena`. At cnt==1 with `ena`, go to FLUSH_DRAIN.
  - If N_TAPS==1, skip straight to FLUSH_DRAIN.
- FLUSH_DRAIN:
  - s_ready = 0.
  - fir_ena = adv_ok & |vld_sr.
  - fir_data_in = 0, real flag 0.
  - When vld_sr==0 and !tail_pend, pulse flush_done and return to RUN.
- `flush` asserted while already flushing is ignored.
- The pipeline never auto-advances in RUN. A lone sample stays in flight until more input or a flush arrives. Inserting bubbles would corrupt the filter history.
- FIFO:
  - Show-ahead: m_valid = !empty, m_data = head.
  - Pop when m_valid & m_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Full is taken from the registered count; there is no pop bypass.
- No arithmetic is performed on data. Widths pass through unchanged.

## Timing
- Reset clears state to RUN, vld_sr=0, tail_pend=0, the FIFO to empty, and cnt=0.
- Output values during reset:
  - s_ready=1.
  - fir_ena=0, fir_data_in=0.
  - m_valid=0, m_data=0.
  - flush_busy=0, flush_done=0.
- Streaming latency: a sample accepted at edge T produces a result in `fir_data_out` after edge T+3, provided enas occur at T+1..T+3. The result is pushed at the next edge, so m_valid is seen one cycle after that.
- No combinational path from m_ready to s_ready or fir_ena.
- Reset asserted mid-flush or mid-stream abandons everything immediately. The FIR is reset by the same reset_n.

## Configuration
- FIR_CTRL_FLUSH_EN defined: the FLUSH_TAIL and FLUSH_DRAIN states and cnt are present, and flush behaves as specified.
- FIR_CTRL_FLUSH_EN not defined: the `flush` input is ignored, flush_busy and flush_done are tied 0, and the state machine is RUN only.

## Structure
- Package `fir_pkg`: state encoding (RUN/FLUSH_TAIL/FLUSH_DRAIN) and default width and depth constants shared with the FIR.
- Sub-module `fir_ctrl_fifo`: synchronous show-ahead FIFO with parameters OUT_WIDTH and FIFO_DEPTH, and outputs full, empty and count.

## Test plan
FIR coefficients are 10, 20, 30, 40 throughout.
- Impulse: input 1, then flush, m_ready=1 → m_data 10, 20, 30, 40. flush_done pulses once, after the last result is pushed.
- Step: five samples of 1, then flush → 10, 30, 60, 100, 100, 90, 70, 40.
- Backpressure: m_ready=0, stream 8 samples → s_ready drops once the FIFO is full with tail_pend set. No result is lost. Releasing m_ready yields the full ordered sequence.
- Simultaneous push/pop with a full FIFO and m_ready=1 → count steady, one result per cycle, no duplicates.
- Reset during FLUSH_TAIL → all outputs go to their reset values. Afterwards an impulse gives 10, 20, 30, 40.
- Build without FIR_CTRL_FLUSH_EN → flush pulses have no effect, and flush_busy and flush_done stay 0.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: controller state encoding and default sizes
// shared between the FIR datapath and its stream controller.
package fir_pkg;

   localparam int DEF_DATA_WIDTH = 18;
   localparam int DEF_OUT_WIDTH  = 38;
   localparam int DEF_N_TAPS     = 4;
   localparam int DEF_LATENCY    = 4;
   localparam int DEF_FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      RUN         = 2'd0,
      FLUSH_TAIL  = 2'd1,
      FLUSH_DRAIN = 2'd2
   } ctrl_state_t;

endpackage

// File: rtl/fir_ctrl_fifo.sv
// fir_ctrl_fifo: show-ahead result FIFO, power-of-two depth,
// registered count, no pop-to-push bypass when full.
module fir_ctrl_fifo
   import fir_pkg::*;
#(
   parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          push,
   input  logic [OUT_WIDTH-1:0]          push_data,
   input  logic                          pop,
   output logic [OUT_WIDTH-1:0]          pop_data,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [AW:0]          cnt_q;
   logic                 do_push;
   logic                 do_pop;

   assign full     = (cnt_q == (AW+1)'(FIFO_DEPTH));
   assign empty    = (cnt_q == '0);
   assign count    = cnt_q;
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign pop_data = mem[rd_ptr];

   // storage, cleared so the head reads zero out of reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // pointers wrap naturally at the power-of-two depth
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/fir_stream_ctrl.sv
// fir_stream_ctrl: stream sequencer and result capture for the FIR.
// Flush sequence (tail + drain) is built only with FIR_CTRL_FLUSH_EN.
module fir_stream_ctrl
   import fir_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
   parameter int N_TAPS     = DEF_N_TAPS,
   parameter int LATENCY    = DEF_LATENCY,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  s_valid,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  s_ready,
   output logic                  fir_ena,
   output logic [DATA_WIDTH-1:0] fir_data_in,
   input  logic [OUT_WIDTH-1:0]  fir_data_out,
   output logic                  m_valid,
   output logic [OUT_WIDTH-1:0]  m_data,
   input  logic                  m_ready,
   input  logic                  flush,
   output logic                  flush_busy,
   output logic                  flush_done
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [LATENCY-1:0]    vld_sr;
   logic [LATENCY-1:0]    vld_nxt;
   logic                  tail_pend;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  push;
   logic                  adv_ok;
   logic                  ena;
   logic                  real_flag;
   logic                  s_ready_c;
   logic [DATA_WIDTH-1:0] data_mux;
   logic [AW:0]           unused_count;

   // an advance may not overwrite a result still waiting for space
   assign push        = tail_pend & ~fifo_full;
   assign adv_ok      = ~tail_pend | ~fifo_full;
   assign fir_ena     = reset_n & ena;
   assign fir_data_in = reset_n ? data_mux : '0;
   assign s_ready     = s_ready_c;
   assign m_valid     = ~fifo_empty;

   // occupancy after an advance: shift in this slot's real flag
   always_comb begin
      vld_nxt    = vld_sr << 1;
      vld_nxt[0] = real_flag;
   end

   // slot tracking; pending flag re-evaluated on every advance
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_sr    <= '0;
         tail_pend <= 1'b0;
      end else if (fir_ena) begin
         vld_sr    <= vld_nxt;
         tail_pend <= vld_nxt[LATENCY-1];
      end else if (push) begin
         tail_pend <= 1'b0;
      end
   end

`ifdef FIR_CTRL_FLUSH_EN
   localparam int CW = $clog2(N_TAPS) + 1;

   ctrl_state_t   state_q;
   ctrl_state_t   state_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // flush sequencer state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // next state and stream/FIR controls per state
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      s_ready_c  = 1'b0;
      ena        = 1'b0;
      data_mux   = '0;
      real_flag  = 1'b1;
      flush_busy = 1'b1;
      flush_done = 1'b0;
      unique case (state_q)
         RUN: begin
            flush_busy = 1'b0;
            s_ready_c  = adv_ok;
            ena        = s_valid & adv_ok;
            data_mux   = s_data;
            if (flush) begin
               if (N_TAPS > 1) begin
                  state_d = FLUSH_TAIL;
                  cnt_d   = CW'(N_TAPS - 1);
               end else begin
                  state_d = FLUSH_DRAIN;
               end
            end
         end
         FLUSH_TAIL: begin
            ena = adv_ok;
            if (adv_ok) begin
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) state_d = FLUSH_DRAIN;
            end
         end
         FLUSH_DRAIN: begin
            real_flag = 1'b0;
            ena       = adv_ok & (|vld_sr);
            if (~(|vld_sr) & ~tail_pend) begin
               flush_done = 1'b1;
               state_d    = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end
`else
   logic unused_flush;

   assign unused_flush = flush;

   // streaming only: the pipeline advances solely on accepted samples
   always_comb begin
      s_ready_c  = adv_ok;
      ena        = s_valid & adv_ok;
      data_mux   = s_data;
      real_flag  = 1'b1;
      flush_busy = 1'b0;
      flush_done = 1'b0;
   end
`endif

   fir_ctrl_fifo #(
      .OUT_WIDTH  (OUT_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (fir_data_out),
      .pop       (m_ready),
      .pop_data  (m_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (unused_count)
   );

endmodule
